// File: rtl/div_pkg.sv
// Shared encodings for the iterative divider.
// Function codes mirror funct3[1:0] of the RV32M divide group.
package div_pkg;

  localparam logic [1:0] FN_DIV  = 2'b00;
  localparam logic [1:0] FN_DIVU = 2'b01;
  localparam logic [1:0] FN_REM  = 2'b10;
  localparam logic [1:0] FN_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left,
// trial-subtract the divisor, keep the result on no borrow.
module div_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_shift;
  logic             w_ok;

  assign w_shift = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};
  assign w_trial = {i_rem, i_quo[WIDTH-1]} - {1'b0, i_div};
  assign w_ok    = ~w_trial[WIDTH];

  assign o_rem = w_ok ? w_trial[WIDTH-1:0] : w_shift;
  assign o_quo = {i_quo[WIDTH-2:0], w_ok};

endmodule

// File: rtl/div_unit.sv
// RV32M iterative divider: DIV/DIVU/REM/REMU, one quotient
// bit per cycle, with a two-cycle path for /0 and overflow.
import div_pkg::*;

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] out
);

  localparam logic [4:0] LAST = 5'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_sel_rem;
  logic             r_busy;
  logic             r_valid;
  logic [WIDTH-1:0] r_out;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_dz;
  logic             w_ovf;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_quo_n;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_signed = (func == FN_DIV) || (func == FN_REM);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;
  assign w_dz     = (b == '0);
  assign w_ovf    = w_signed && (a == MIN) && (b == '1);

  assign w_q_fix = r_qneg ? -r_quo : r_quo;
  assign w_r_fix = r_rneg ? -r_rem : r_rem;

  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_n),
    .o_quo (w_quo_n)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_sel_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_out     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_sel_rem <= func[1];
              r_cnt     <= '0;
              r_busy    <= 1'b1;
              // Fast-path results are final: no sign fix-up.
              if (w_dz) begin
                r_quo   <= '1;
                r_rem   <= a;
                r_qneg  <= 1'b0;
                r_rneg  <= 1'b0;
                r_state <= S_FIX;
              end else if (w_ovf) begin
                r_quo   <= MIN;
                r_rem   <= '0;
                r_qneg  <= 1'b0;
                r_rneg  <= 1'b0;
                r_state <= S_FIX;
              end else begin
                r_quo   <= w_a_mag;
                r_rem   <= '0;
                r_div   <= w_b_mag;
                r_qneg  <= w_a_neg ^ w_b_neg;
                r_rneg  <= w_a_neg;
                r_state <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST) r_state <= S_FIX;
          end
          S_FIX: begin
            r_out   <= r_sel_rem ? w_r_fix : w_q_fix;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign out   = r_out;

endmodule
